// File: rtl/vga_video_gen.sv
// VGA timing generator with a registered RGB test pattern aligned to delayed sync.
// Define VGA_PATTERN_EN to build the pattern logic; otherwise vid_r/g/b are tied to 0.
module vga_video_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 11,
  parameter int COLOR_W   = 4,
  parameter int CELL_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vid_hsync,
  output logic               vid_vsync,
  output logic               vid_de,
  output logic [COLOR_W-1:0] vid_r,
  output logic [COLOR_W-1:0] vid_g,
  output logic [COLOR_W-1:0] vid_b,
  output logic [7:0]         frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             at_origin, in_hs, in_vs;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign in_hs     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_MAX) begin
        h_cnt <= '0;
        if (v_cnt == V_MAX) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pulses are qualified by en every cycle so they never stretch across a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vid_hsync   <= ~HSYNC_POL;
      vid_vsync   <= ~VSYNC_POL;
      vid_de      <= 1'b0;
    end else begin
      line_start  <= en && (h_cnt == '0);
      frame_start <= en && at_origin;
      if (en) begin
        x         <= h_cnt;
        y         <= v_cnt;
        de        <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync     <= in_hs ? HSYNC_POL : ~HSYNC_POL;
        vsync     <= in_vs ? VSYNC_POL : ~VSYNC_POL;
        vid_hsync <= hsync;
        vid_vsync <= vsync;
        vid_de    <= de;
      end
    end
  end

`ifdef VGA_PATTERN_EN
  logic [1:0]         mode_q;
  logic [2:0]         bar, bar_col;
  logic [CNT_W-1:0]   xs;
  logic [COLOR_W-1:0] pr, pg, pb;

  always_ff @(posedge clk) begin
    if (!rst_n)                 mode_q <= 2'b00;
    else if (en && at_origin)   mode_q <= mode;
  end

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (x >= CNT_W'(k * H_ACTIVE / 8)) bar = 3'(k);
  end

  // Bar colour index 7-k is laid out {g,r,b} so the bars run
  // white, yellow, cyan, green, magenta, red, blue, black.
  assign bar_col = 3'd7 - bar;
  assign xs      = x + CNT_W'(frame_cnt);

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      2'b01: pr = {COLOR_W{x[CELL_LOG2] ^ y[CELL_LOG2]}};
      2'b10: begin
        pg = {COLOR_W{bar_col[2]}};
        pr = {COLOR_W{bar_col[1]}};
        pb = {COLOR_W{bar_col[0]}};
      end
      2'b11: begin
        pr = {COLOR_W{xs[CELL_LOG2] ^ y[CELL_LOG2]}};
        pg = pr;
        pb = pr;
      end
      default: ;
    endcase
    if (!de) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid_r <= '0;
      vid_g <= '0;
      vid_b <= '0;
    end else if (en) begin
      vid_r <= pr;
      vid_g <= pg;
      vid_b <= pb;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign vid_r = '0;
  assign vid_g = '0;
  assign vid_b = '0;
`endif
endmodule

// File: tb/tb_vga_video_gen.sv
// Directed bench for vga_video_gen on a reduced 80x22 raster (64x16 active, cell 4).
module tb_vga_video_gen;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [1:0] mode;
  logic       hsync, vsync, de, line_start, frame_start;
  logic       vid_hsync, vid_vsync, vid_de;
  logic [7:0] x, y, frame_cnt;
  logic [3:0] vid_r, vid_g, vid_b;

`ifdef VGA_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  localparam logic [3:0] FF = PAT ? 4'hF : 4'h0;

  int passed = 0, total = 0, cyc = 0;

  vga_video_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .CNT_W(8), .COLOR_W(4), .CELL_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Steps at least once, until stage 1 shows (xx,yy).
  task automatic run_to(input int xx, input int yy);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(x == 8'(xx) && y == 8'(yy)) && n < 5000);
    total++;
    assert (n < 5000) passed++;
    else $error("FAIL run_to(%0d,%0d): timed out after %0d cycles, expected < 5000", xx, yy, n);
  endtask

  task automatic chk_rgb(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    chk({tag, "_rgb"}, {vid_r, vid_g, vid_b}, {r, g, b});
  endtask

  initial begin
    int bad_align, bad_rgb, bad_ls, bad_fs, bad_hs, bad_vs, bad_de, bad_pulse;
    int n_ls, n_fs, ls_last, fs_last, hs_low, de_line, de_lines, fs_seen, fs_t, period;
    logic p_hs, p_vs, p_de, p_ls, prev_hsync, en_used;

    rst_n = 1'b0; en = 1'b0; mode = 2'b00;
    repeat (3) step();
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_de", de, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_pulses", {line_start, frame_start}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_vid", {vid_hsync, vid_vsync, vid_de}, 3'b110);
    chk_rgb("rst", 0, 0, 0);

    rst_n = 1'b1; en = 1'b1;
    step();
    chk("first_xy", {x, y}, 0);
    chk("first_de", de, 1);
    chk("first_pulses", {line_start, frame_start}, 2'b11);
    ls_last = cyc; fs_last = cyc;
    step();
    chk("second_x", x, 1);
    chk("second_pulses", {line_start, frame_start}, 0);
    chk("second_vid_de", vid_de, 1);

    // Free-run three frames, auditing timing every cycle.
    bad_align = 0; bad_rgb = 0; bad_ls = 0; bad_fs = 0; bad_hs = 0; bad_vs = 0; bad_de = 0;
    n_ls = 0; n_fs = 0; hs_low = 0; de_line = 2; de_lines = 0;
    p_hs = hsync; p_vs = vsync; p_de = de; prev_hsync = hsync;
    for (int i = 0; i < 5278; i++) begin
      step();
      if (vid_hsync !== p_hs || vid_vsync !== p_vs || vid_de !== p_de) bad_align++;
      if ({vid_r, vid_g, vid_b} !== 12'h0) bad_rgb++;
      if (line_start) begin
        if (cyc - ls_last != 80 || x !== 8'd0) bad_ls++;
        ls_last = cyc; n_ls++;
      end
      if (frame_start) begin
        if (cyc - fs_last != 1760 || y !== 8'd0) bad_fs++;
        fs_last = cyc; n_fs++;
      end
      if (!hsync) begin
        hs_low++;
        if (prev_hsync && x !== 8'd68) bad_hs++;
      end
      if (vsync !== !(y == 8'd18 || y == 8'd19)) bad_vs++;
      if (de) de_line++;
      if (x == 8'd79) begin
        if (hs_low != 8) bad_hs++;
        if (de_line != ((y < 8'd16) ? 64 : 0)) bad_de++;
        if (de_line != 0) de_lines++;
        if (y == 8'd21) begin
          if (de_lines != 16) bad_de++;
          de_lines = 0;
        end
        hs_low = 0; de_line = 0;
      end
      prev_hsync = hsync;
      p_hs = hsync; p_vs = vsync; p_de = de;
    end
    chk("vid_align", bad_align, 0);
    chk("mode0_black", bad_rgb, 0);
    chk("ls_period", bad_ls, 0);
    chk("fs_period", bad_fs, 0);
    chk("n_line_start", n_ls, 65);
    chk("n_frame_start", n_fs, 2);
    chk("hsync_width", bad_hs, 0);
    chk("vsync_lines", bad_vs, 0);
    chk("de_counts", bad_de, 0);
    chk("fcnt_3", frame_cnt, 3);
    chk("end_xy", {x, y}, {8'd79, 8'd21});

    // Red checkerboard, frame 3.
    mode = 2'b01;
    step();
    chk("f3_origin", {x, y, frame_start}, {8'd0, 8'd0, 1'b1});
    step();
    chk_rgb("ck_0_0", 0, 0, 0);
    run_to(4, 0);  step(); chk_rgb("ck_4_0", FF, 0, 0);
    run_to(70, 1); step(); chk_rgb("ck_blank", 0, 0, 0);
    run_to(4, 4);  step(); chk_rgb("ck_4_4", 0, 0, 0);
    run_to(0, 10);
    mode = 2'b10;
    run_to(4, 10); step(); chk_rgb("ck_held", FF, 0, 0);

    // Colour bars take over at the next frame start (frame 4).
    run_to(0, 0);  step(); chk_rgb("bar_0", FF, FF, FF);
    run_to(8, 0);  step(); chk_rgb("bar_8", FF, FF, 0);
    run_to(63, 0); step(); chk_rgb("bar_63", 0, 0, 0);
    chk("bar_63_vid_de", vid_de, 1);
    step(); chk_rgb("bar_blank", 0, 0, 0);
    mode = 2'b11;
    run_to(8, 1);  step(); chk_rgb("bar_held", FF, FF, 0);

    // Scrolling white checkerboard, frame 5: offset 5 flips cell at x=0 and x=3.
    run_to(0, 0);
    chk("fcnt_5", frame_cnt, 5);
    step(); chk_rgb("sc_0_0", FF, FF, FF);
    run_to(3, 0);  step(); chk_rgb("sc_3_0", 0, 0, 0);

    // Pulse drops after a stalled cycle and stage 1 holds.
    run_to(79, 0);
    en = 1'b0; step();
    chk("stall_hold", {x, line_start}, {8'd79, 1'b0});
    en = 1'b1; step();
    chk("resume_ls", {x, y, line_start}, {8'd0, 8'd1, 1'b1});
    en = 1'b0; step();
    chk("stall_ls_drop", {x, line_start}, {8'd0, 1'b0});

    // en toggling every clock doubles the frame period.
    bad_pulse = 0; fs_seen = 0; fs_t = 0; period = 0; p_ls = line_start;
    for (int i = 0; i < 10000 && fs_seen < 2; i++) begin
      en_used = en;
      step();
      if ((line_start || frame_start) && !en_used) bad_pulse++;
      if (line_start && p_ls) bad_pulse++;
      if (frame_start) begin
        if (fs_seen == 1) period = cyc - fs_t;
        fs_t = cyc; fs_seen++;
      end
      p_ls = line_start;
      en = ~en;
    end
    chk("toggle_fs_seen", fs_seen, 2);
    chk("toggle_period", period, 3520);
    chk("toggle_pulses", bad_pulse, 0);

    // Reset mid-line.
    en = 1'b1;
    run_to(30, 3);
    rst_n = 1'b0; step();
    chk("mid_rst_xy", {x, y}, 0);
    chk("mid_rst_de", {de, line_start, frame_start}, 0);
    chk("mid_rst_sync", {hsync, vsync, vid_hsync, vid_vsync, vid_de}, 5'b11110);
    chk("mid_rst_fcnt", frame_cnt, 0);
    chk_rgb("mid_rst", 0, 0, 0);
    rst_n = 1'b1; step();
    chk("post_rst_fs", {x, y, de, line_start, frame_start}, {8'd0, 8'd0, 3'b111});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
